// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states
// and a small decode helper.
package mdu_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_MTHI  = 4'd4;
  localparam logic [3:0] MDU_MTLO  = 4'd5;
  localparam logic [3:0] MDU_MADD  = 4'd6;
  localparam logic [3:0] MDU_MADDU = 4'd7;
  localparam logic [3:0] MDU_MSUB  = 4'd8;
  localparam logic [3:0] MDU_MSUBU = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_ACC  = 2'd3
  } mdu_state_t;

  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD) || (op == MDU_MSUB);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Shared one-bit-per-cycle datapath: radix-2 shift-add multiply or restoring
// divide on unsigned magnitudes, plus the iteration counter.
module mdu_iter_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic                 div_mode,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 last,
  output logic [2*WIDTH-1:0]   acc
);

  logic [WIDTH-1:0]   opb_q;
  logic [CNT_W-1:0]   cnt;
  logic               mode_q;
  logic [WIDTH:0]     x;
  logic [WIDTH+1:0]   yy;
  logic [WIDTH+1:0]   sum;
  logic [2*WIDTH-1:0] acc_n;

  // One adder serves both modes: add multiplicand, or subtract divisor from
  // the shifted partial remainder (negative result means restore).
  always_comb begin
    x     = mode_q ? {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} : {1'b0, acc[2*WIDTH-1:WIDTH]};
    yy    = mode_q ? ~{2'b00, opb_q} : {2'b00, opb_q};
    sum   = {1'b0, x} + yy + {{(WIDTH+1){1'b0}}, mode_q};
    acc_n = {1'b0, acc[2*WIDTH-1:1]};
    if (mode_q) begin
      if (sum[WIDTH+1])
        acc_n = {x[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_n = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else if (acc[0]) begin
      acc_n = {sum[WIDTH:0], acc[WIDTH-1:1]};
    end
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      opb_q  <= '0;
      mode_q <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= {{WIDTH{1'b0}}, op_a};
      opb_q  <= op_b;
      mode_q <= div_mode;
      cnt    <= '0;
    end else if (step) begin
      acc    <= acc_n;
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mdu_hilo_seq.sv
// Iterative MDU owning HI/LO: handshake, FSM, sign handling and result commit.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) enabled by MDU_MADD_EN.
module mdu_hilo_seq
  import mdu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  mdu_state_t         state, state_n;
  logic               op_mul, op_div, accept, start;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               neg_res, neg_rem, is_div, div0, fix_wr;
  logic [WIDTH-1:0]   rs_q;
  logic               core_last;
  logic [2*WIDTH-1:0] core_acc, prod;
  logic [WIDTH-1:0]   quot, rem;
`ifdef MDU_MADD_EN
  logic               is_acc, is_sub, acc_op, sub_op;
`endif

  always_comb begin
    op_mul = (op_code == MDU_MULT) || (op_code == MDU_MULTU);
    op_div = (op_code == MDU_DIV) || (op_code == MDU_DIVU);
`ifdef MDU_MADD_EN
    acc_op = (op_code == MDU_MADD) || (op_code == MDU_MADDU) ||
             (op_code == MDU_MSUB) || (op_code == MDU_MSUBU);
    sub_op = (op_code == MDU_MSUB) || (op_code == MDU_MSUBU);
    op_mul = op_mul || acc_op;
`endif
  end

  assign sign_a   = op_is_signed(op_code) & rs_data[WIDTH-1];
  assign sign_b   = op_is_signed(op_code) & rt_data[WIDTH-1];
  assign mag_a    = cond_neg(rs_data, sign_a);
  assign mag_b    = cond_neg(rt_data, sign_b);
  assign op_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  // flush wins over a same-cycle request, so the request is dropped
  assign accept   = op_valid && op_ready && !flush;
  assign start    = accept && (op_mul || op_div);

  mdu_iter_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (start),
    .step     (state == ST_CALC),
    .div_mode (op_div),
    .op_a     (mag_a),
    .op_b     (mag_b),
    .last     (core_last),
    .acc      (core_acc)
  );

  assign prod = cond_neg2(core_acc, neg_res);
  assign quot = cond_neg(core_acc[WIDTH-1:0], neg_res);
  assign rem  = cond_neg(core_acc[2*WIDTH-1:WIDTH], neg_rem);

`ifdef MDU_MADD_EN
  assign fix_wr = (state == ST_FIX) && !is_acc;
`else
  assign fix_wr = (state == ST_FIX);
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start) state_n = ST_CALC;
      ST_CALC: if (core_last) state_n = ST_FIX;
`ifdef MDU_MADD_EN
      ST_FIX:  state_n = is_acc ? ST_ACC : ST_IDLE;
`else
      ST_FIX:  state_n = ST_IDLE;
`endif
      default: state_n = ST_IDLE;
    endcase
    if (flush) state_n = ST_IDLE;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      is_div  <= 1'b0;
      div0    <= 1'b0;
      rs_q    <= '0;
`ifdef MDU_MADD_EN
      is_acc  <= 1'b0;
      is_sub  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept && op_code == MDU_MTHI) hi <= rs_data;
      if (accept && op_code == MDU_MTLO) lo <= rs_data;
      if (start) begin
        neg_res <= sign_a ^ sign_b;
        neg_rem <= sign_a;
        is_div  <= op_div;
        div0    <= (rt_data == '0);
        rs_q    <= rs_data;
`ifdef MDU_MADD_EN
        is_acc  <= acc_op;
        is_sub  <= sub_op;
`endif
      end
      // Commit happens only if the op survives to its final edge unflushed
      if (fix_wr && !flush) begin
        done <= 1'b1;
        if (!is_div)   {hi, lo} <= prod;
        else if (div0) begin
          lo <= '1;
          hi <= rs_q;
        end else begin
          lo <= quot;
          hi <= rem;
        end
      end
`ifdef MDU_MADD_EN
      if (state == ST_ACC && !flush) begin
        done     <= 1'b1;
        {hi, lo} <= is_sub ? ({hi, lo} - prod) : ({hi, lo} + prod);
      end
`endif
    end
  end

endmodule

// File: tb/tb_mdu_hilo_seq.sv
// Directed + scoreboard bench for mdu_hilo_seq at WIDTH=32.
module tb_mdu_hilo_seq;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         op_valid = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   op_code = 4'd0;
  logic [W-1:0] rs_data = '0;
  logic [W-1:0] rt_data = '0;
  logic         op_ready, busy, done;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
    int           acc_cyc;
  } exp_t;
  exp_t sb[$];

  mdu_hilo_seq #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_code  (op_code),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    op_valid = 1'b1;
    op_code  = op;
    rs_data  = a;
    rt_data  = b;
    tick();
    op_valid = 1'b0;
    rs_data  = $urandom;
    rt_data  = $urandom;
  endtask

  task automatic expect_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] ehi,
                           input logic [W-1:0] elo, input int lat);
    exp_t e;
    issue(op, a, b);
    e.tag = tag; e.hi = ehi; e.lo = elo; e.lat = lat; e.acc_cyc = cyc;
    sb.push_back(e);
    chk({tag, "_busy"}, 64'(busy), 64'(1));
  endtask

  task automatic wait_done();
    exp_t e;
    e = sb.pop_front();
    while (done !== 1'b1 && (cyc - e.acc_cyc) < 200) tick();
    chk({e.tag, "_lat"}, 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
    chk({e.tag, "_hilo"}, {hi, lo}, {e.hi, e.lo});
    chk({e.tag, "_ready"}, 64'(op_ready), 64'(1));
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [63:0]         ea, eb;
    logic signed [W-1:0] sa, sbv;
    logic [W-1:0]        q, r;
    ea = {{W{a[W-1]}}, a};
    eb = {{W{b[W-1]}}, b};
    sa = a;
    sbv = b;
    case (op)
      MDU_MULTU: return {32'd0, a} * {32'd0, b};
      MDU_MULT:  return ea * eb;
      MDU_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sbv;
        r = sa % sbv;
        return {r, q};
      end
    endcase
  endfunction

  initial begin
    int dcount;
    logic [63:0] m;
    logic [3:0] rop;
    logic [W-1:0] ra, rb;

    // reset state
    tick(); tick();
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_ready", 64'(op_ready), 64'(1));
    RST = 1'b1;
    tick();

    // MTHI then a flushed multiply
    issue(MDU_MTHI, 32'h1234, 32'h0);
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_busy", 64'(busy), 64'(0));
    chk("mthi_done", 64'(done), 64'(0));
    issue(MDU_MULTU, 32'd5, 32'd6);
    chk("fl_busy", 64'(busy), 64'(1));
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_ready", 64'(op_ready), 64'(1));
    chk("fl_hilo", {hi, lo}, {32'h1234, 32'h0});
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) dcount++;
    end
    chk("fl_nodone", 64'(dcount), 64'(0));

    // flush beats a simultaneous request
    op_valid = 1'b1; op_code = MDU_MULTU; rs_data = 32'd2; rt_data = 32'd3; flush = 1'b1;
    tick();
    op_valid = 1'b0; flush = 1'b0;
    chk("flpri_busy", 64'(busy), 64'(0));

    // unknown op codes are NOPs
    issue(4'hF, 32'hAAAA, 32'h5555);
    chk("nop_busy", 64'(busy), 64'(0));
    chk("nop_hilo", {hi, lo}, {32'h1234, 32'h0});
    tick();
    chk("nop_done", 64'(done), 64'(0));
`ifndef MDU_MADD_EN
    issue(MDU_MADD, 32'd3, 32'd4);
    chk("madd_nop_busy", 64'(busy), 64'(0));
`endif

    // directed results, issued back to back in each done cycle
    expect_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34);
    wait_done();
    expect_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34);
    wait_done();
    expect_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
    wait_done();
    expect_op("divu_zero", MDU_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 34);
    wait_done();
    expect_op("div_zero_s", MDU_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 34);
    wait_done();
    expect_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34);
    wait_done();

    // request while busy is ignored
    expect_op("mult_small", MDU_MULT, 32'd3, 32'd4, 32'h0, 32'd12, 34);
    op_valid = 1'b1; op_code = MDU_MTHI; rs_data = 32'hDEAD;
    tick();
    op_valid = 1'b0;
    chk("busy_ignore_hi", 64'(hi), 64'h0);
    wait_done();

    // scoreboard-driven random operations
    for (int i = 0; i < 8; i++) begin
      rop = 4'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(1, 50)) : $urandom);
      m = model(rop, ra, rb);
      expect_op($sformatf("rand%0d", i), rop, ra, rb, m[63:32], m[31:0], 34);
      wait_done();
    end

`ifdef MDU_MADD_EN
    issue(MDU_MTHI, 32'd0, 32'd0);
    issue(MDU_MTLO, 32'd10, 32'd0);
    expect_op("maddu", MDU_MADDU, 32'd3, 32'd4, 32'd0, 32'd22, 35);
    wait_done();
    expect_op("msub", MDU_MSUB, 32'd2, 32'hFFFF_FFFD, 32'd0, 32'd28, 35);
    wait_done();
`endif

    // asynchronous reset in the middle of CALC
    tick();
    issue(MDU_MULTU, 32'd7, 32'd9);
    repeat (5) tick();
    #2 RST = 1'b0;
    #1;
    chk("arst_hilo", {hi, lo}, 64'd0);
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    tick();
    RST = 1'b1;
    tick();
    expect_op("post_rst", MDU_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 34);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
